// File: rtl/cx_acc_responder.sv
// CX responder: one request at a time against NUM_STATES accumulator contexts.
// Optional `CX_MAC_EARLY_EXIT_EN ends the shift-add multiply once the remaining multiplier bits are zero.
module cx_acc_responder #(
    parameter int NUM_STATES  = 4,
    parameter int STATE_IDX_W = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cx_req_valid_i,
    output logic                   cx_req_ready_o,
    input  logic [2:0]             cx_req_func_i,
    input  logic [STATE_IDX_W-1:0] cx_req_state_i,
    input  logic [31:0]            cx_req_opa_i,
    input  logic [31:0]            cx_req_opb_i,
    output logic                   cx_resp_valid_o,
    input  logic                   cx_resp_ready_i,
    output logic [31:0]            cx_resp_data_o,
    output logic [1:0]             cx_resp_status_o,
    input  logic                   cx_flush_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] F_ADD  = 3'd0;
    localparam logic [2:0] F_MAC  = 3'd1;
    localparam logic [2:0] F_READ = 3'd2;
    localparam logic [2:0] F_SWAP = 3'd3;
    localparam logic [2:0] F_CLR  = 3'd4;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_ILL_FUNC = 2'd1;
    localparam logic [1:0] ST_ILL_CTX  = 2'd2;

    localparam logic [STATE_IDX_W:0] LP_NUM = NUM_STATES[STATE_IDX_W:0];

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [STATE_IDX_W-1:0] r_idx;
    logic                   r_ctx_ok;
    logic [31:0]            r_mcand;
    logic [31:0]            r_mplier;
    logic [31:0]            r_prod;
    logic [4:0]             r_cnt;
    logic [31:0]            r_resp_data;
    logic [1:0]             r_resp_status;
    logic                   r_wr_en;
    logic [31:0]            r_wr_val;
    logic [31:0]            r_acc [NUM_STATES];

    logic                   w_accept;
    logic                   w_is_mac;
    logic                   w_commit;
    logic [STATE_IDX_W-1:0] w_sel_idx;
    logic                   w_sel_ok;
    logic [31:0]            w_sel_acc;
    logic [31:0]            w_mul_step;
    logic [31:0]            w_prod_nxt;
    logic                   w_mul_last;
    logic [31:0]            w_mac_data;
    logic [31:0]            w_op_data;
    logic [1:0]             w_op_status;
    logic                   w_op_wr_en;
    logic [31:0]            w_op_wr_val;

    assign w_accept = (r_state == S_IDLE) & cx_req_valid_i & ~cx_flush_i;
    assign w_is_mac = (cx_req_func_i == F_MAC);
    assign w_commit = (r_state == S_RESP) & cx_resp_ready_i
                    & ~cx_flush_i & r_wr_en;

    // In IDLE the incoming index is looked up; afterwards the latched one.
    always_comb begin
        w_sel_idx = (r_state == S_IDLE) ? cx_req_state_i : r_idx;
        w_sel_ok  = ({1'b0, w_sel_idx} < LP_NUM);
        w_sel_acc = '0;
        for (int k = 0; k < NUM_STATES; k++) begin
            if (w_sel_idx == STATE_IDX_W'(k)) begin
                w_sel_acc = r_acc[k];
            end
        end
    end

    always_comb begin
        w_mul_step = r_mplier[0] ? r_mcand : '0;
        w_prod_nxt = r_prod + w_mul_step;
        w_mul_last = (r_cnt == 5'd31);
`ifdef CX_MAC_EARLY_EXIT_EN
        w_mul_last = w_mul_last | (r_mplier[31:1] == 31'd0);
`endif
        w_mac_data = r_ctx_ok ? (w_sel_acc + w_prod_nxt) : '0;
    end

    always_comb begin
        w_op_data   = '0;
        w_op_status = ST_OK;
        w_op_wr_en  = 1'b0;
        w_op_wr_val = '0;
        if (!w_sel_ok) begin
            w_op_status = ST_ILL_CTX;
        end else begin
            case (cx_req_func_i)
                F_ADD: begin
                    w_op_data   = w_sel_acc + cx_req_opa_i;
                    w_op_wr_en  = 1'b1;
                    w_op_wr_val = w_sel_acc + cx_req_opa_i;
                end
                F_MAC: begin
                    w_op_data = '0;
                end
                F_READ: begin
                    w_op_data = w_sel_acc;
                end
                F_SWAP: begin
                    w_op_data   = w_sel_acc;
                    w_op_wr_en  = 1'b1;
                    w_op_wr_val = cx_req_opa_i;
                end
                F_CLR: begin
                    w_op_wr_en = 1'b1;
                end
                default: begin
                    w_op_status = ST_ILL_FUNC;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (cx_flush_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cx_req_valid_i) begin
                        w_state_nxt = w_is_mac ? S_MUL : S_RESP;
                    end
                end
                S_MUL: begin
                    if (w_mul_last) begin
                        w_state_nxt = S_RESP;
                    end
                end
                S_RESP: begin
                    if (cx_resp_ready_i) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cx_req_ready_o   = (r_state == S_IDLE);
        cx_resp_valid_o  = (r_state == S_RESP);
        cx_resp_data_o   = r_resp_data;
        cx_resp_status_o = r_resp_status;
    end

    // Response fields only change on acceptance or at the end of MUL,
    // so they are stable throughout RESP.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx         <= '0;
            r_ctx_ok      <= 1'b0;
            r_mcand       <= '0;
            r_mplier      <= '0;
            r_prod        <= '0;
            r_cnt         <= '0;
            r_resp_data   <= '0;
            r_resp_status <= ST_OK;
            r_wr_en       <= 1'b0;
            r_wr_val      <= '0;
        end else if (w_accept) begin
            r_idx    <= cx_req_state_i;
            r_ctx_ok <= w_sel_ok;
            if (w_is_mac) begin
                r_mcand  <= cx_req_opa_i;
                r_mplier <= cx_req_opb_i;
                r_prod   <= '0;
                r_cnt    <= '0;
            end else begin
                r_resp_data   <= w_op_data;
                r_resp_status <= w_op_status;
                r_wr_en       <= w_op_wr_en;
                r_wr_val      <= w_op_wr_val;
            end
        end else if ((r_state == S_MUL) && !cx_flush_i) begin
            r_mcand  <= {r_mcand[30:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[31:1]};
            r_prod   <= w_prod_nxt;
            r_cnt    <= r_cnt + 5'd1;
            if (w_mul_last) begin
                r_resp_data   <= w_mac_data;
                r_resp_status <= r_ctx_ok ? ST_OK : ST_ILL_CTX;
                r_wr_en       <= r_ctx_ok;
                r_wr_val      <= w_mac_data;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_STATES; k++) begin
                r_acc[k] <= '0;
            end
        end else if (w_commit) begin
            for (int k = 0; k < NUM_STATES; k++) begin
                if (r_idx == STATE_IDX_W'(k)) begin
                    r_acc[k] <= r_wr_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_cx_acc_responder.sv
// Bench for cx_acc_responder: vector table with response scoreboard,
// plus backpressure and flush sequences.
module tb_cx_acc_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_func;
    logic [3:0]  req_state;
    logic [31:0] req_opa;
    logic [31:0] req_opb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_status;
    logic        flush;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  func;
        logic [3:0]  ctx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic [1:0]  status;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  status;
        int          lat;
    } exp_t;

    vec_t tbl [16];
    exp_t sb [$];

    cx_acc_responder #(
        .NUM_STATES  (4),
        .STATE_IDX_W (4)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .cx_req_valid_i   (req_valid),
        .cx_req_ready_o   (req_ready),
        .cx_req_func_i    (req_func),
        .cx_req_state_i   (req_state),
        .cx_req_opa_i     (req_opa),
        .cx_req_opb_i     (req_opb),
        .cx_resp_valid_o  (resp_valid),
        .cx_resp_ready_i  (resp_ready),
        .cx_resp_data_o   (resp_data),
        .cx_resp_status_o (resp_status),
        .cx_flush_i       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input vec_t v);
        int hi;
        hi = 0;
        if (v.func != 3'd1) return 1;
`ifdef CX_MAC_EARLY_EXIT_EN
        for (int i = 0; i < 32; i++) begin
            if (v.b[i]) hi = i + 1;
        end
        return 1 + ((hi < 1) ? 1 : hi);
`else
        return 33 + hi;
`endif
    endfunction

    task automatic drive(input vec_t v);
        @(negedge clk);
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_func  = v.func;
        req_state = v.ctx;
        req_opa   = v.a;
        req_opb   = v.b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Returns the cycle count from the accept edge until valid is seen.
    task automatic wait_resp(input string name, output int lat,
                             output bit got);
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no response want valid", name);
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        exp_t e;
        int   lat;
        bit   got;
        sb.push_back('{v.data, v.status, exp_lat(v)});
        drive(v);
        wait_resp(name, lat, got);
        e = sb.pop_front();
        if (got) begin
            chk({name, "_data"}, resp_data, e.data);
            chk({name, "_status"}, {30'd0, resp_status}, {30'd0, e.status});
            chk({name, "_lat"}, lat, e.lat);
            @(posedge clk);
            #1;
            chk({name, "_ready_after"}, {31'd0, req_ready}, 32'd1);
            chk({name, "_valid_after"}, {31'd0, resp_valid}, 32'd0);
        end
    endtask

    task automatic read_ctx(input string name, input logic [3:0] c,
                            input logic [31:0] d);
        vec_t v;
        v = '{3'd2, c, 32'd0, 32'd0, d, 2'd0};
        run_vec(name, v);
    endtask

    initial begin
        int   lat;
        bit   got;
        int   seen;
        exp_t e;
        vec_t v;

        tbl[0]  = '{3'd2, 4'd0, 32'h0,        32'h0,        32'h0,        2'd0};
        tbl[1]  = '{3'd3, 4'd1, 32'h10,       32'h0,        32'h0,        2'd0};
        tbl[2]  = '{3'd0, 4'd1, 32'hFFFFFFF5, 32'h0,        32'h5,        2'd0};
        tbl[3]  = '{3'd2, 4'd1, 32'h0,        32'h0,        32'h5,        2'd0};
        tbl[4]  = '{3'd0, 4'd2, 32'h7,        32'h0,        32'h7,        2'd0};
        tbl[5]  = '{3'd1, 4'd2, 32'h00010001, 32'h3,        32'h0003000A, 2'd0};
        tbl[6]  = '{3'd6, 4'd2, 32'h1,        32'h1,        32'h0,        2'd1};
        tbl[7]  = '{3'd2, 4'd2, 32'h0,        32'h0,        32'h0003000A, 2'd0};
        tbl[8]  = '{3'd0, 4'd5, 32'h1,        32'h0,        32'h0,        2'd2};
        tbl[9]  = '{3'd7, 4'd5, 32'h1,        32'h0,        32'h0,        2'd2};
        tbl[10] = '{3'd2, 4'd1, 32'h0,        32'h0,        32'h5,        2'd0};
        tbl[11] = '{3'd4, 4'd1, 32'h0,        32'h0,        32'h0,        2'd0};
        tbl[12] = '{3'd2, 4'd1, 32'h0,        32'h0,        32'h0,        2'd0};
        tbl[13] = '{3'd1, 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        2'd0};
        tbl[14] = '{3'd1, 4'd0, 32'h5,        32'h0,        32'h1,        2'd0};
        tbl[15] = '{3'd3, 4'd3, 32'h20,       32'h0,        32'h0,        2'd0};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_func   = '0;
        req_state  = '0;
        req_opa    = '0;
        req_opb    = '0;
        resp_ready = 1'b1;
        flush      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_status", {30'd0, resp_status}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Flush in MUL cycle 10: MSB-only multiplier keeps MUL busy.
        v = '{3'd1, 4'd3, 32'h1, 32'h80000000, 32'h0, 2'd0};
        drive(v);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("fl_mul_valid", {31'd0, resp_valid}, 32'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl_ready", {31'd0, req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) seen++;
            @(posedge clk);
            #1;
        end
        chk("fl_no_resp", seen, 32'd0);
        read_ctx("fl_read", 4'd3, 32'h20);

        // Flush coincident with the response handshake.
        resp_ready = 1'b0;
        v = '{3'd0, 4'd3, 32'h5, 32'h0, 32'h25, 2'd0};
        drive(v);
        wait_resp("flhs", lat, got);
        chk("flhs_data", resp_data, 32'h25);
        resp_ready = 1'b1;
        flush      = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flhs_valid", {31'd0, resp_valid}, 32'd0);
        chk("flhs_ready", {31'd0, req_ready}, 32'd1);
        read_ctx("flhs_read", 4'd3, 32'h20);

        // Backpressure: response held, accumulator untouched until handshake.
        resp_ready = 1'b0;
        v = '{3'd0, 4'd3, 32'h1, 32'h0, 32'h21, 2'd0};
        sb.push_back('{v.data, v.status, 1});
        drive(v);
        wait_resp("bp", lat, got);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_data", resp_data, 32'h21);
            chk("bp_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_acc", dut.r_acc[3], 32'h20);
            @(posedge clk);
            #1;
        end
        e = sb.pop_front();
        chk("bp_data_hs", resp_data, e.data);
        chk("bp_lat", lat, e.lat);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_acc_hs", dut.r_acc[3], 32'h21);
        chk("bp_ready_hs", {31'd0, req_ready}, 32'd1);
        read_ctx("bp_read", 4'd3, 32'h21);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
